// File: rtl/interpol_mc.sv
// Multi-channel piecewise-linear interpolator with runtime-loadable breakpoint tables.
// Result 5 edges after an accepted start; start is ignored while busy, table writes while busy are dropped.
module interpol_mc #(
   parameter int LUTSIZE  = 16,
   parameter int ADDRBITS = 4,
   parameter int N        = 16,
   parameter int QN       = 10,
   parameter int M        = 16,
   parameter int QM       = 10,
   parameter int NCH      = 2,
   parameter int CHBITS   = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [CHBITS-1:0]          ch,
   input  logic signed [N-1:0]        X,
   output logic                       ready,
   output logic signed [M-1:0]        Y,
   input  logic                       lut_we,
   input  logic [CHBITS-1:0]          lut_ch,
   input  logic [ADDRBITS:0]          lut_addr,
   input  logic signed [M-1:0]        lut_data,
   output logic                       lut_drop
);

   localparam int FB = N - ADDRBITS;
   localparam int PW = M + FB + 2;

   if (LUTSIZE != (1 << ADDRBITS) || NCH > (1 << CHBITS) || QN > N || QM > M) begin : g_bad_params
      $error("interpol_mc: inconsistent parameters");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAP,
      S_RD0,
      S_RD1,
      S_MUL,
      S_OUT
   } state_t;

   state_t state, state_nxt;

   logic signed [M-1:0]   tbl [NCH][LUTSIZE+1];

   logic signed [N-1:0]   x_q;
   logic [CHBITS-1:0]     ch_q;
   logic [ADDRBITS-1:0]   idx_q;
   logic [FB-1:0]         frac_q;
   logic signed [M-1:0]   l0_q;
   logic signed [M-1:0]   l1_q;
   logic signed [PW-1:0]  prod_q;

   logic                  wr_ok;
   logic [N-1:0]          u;
   logic [ADDRBITS:0]     idx0;
   logic [ADDRBITS:0]     idx1;
   logic signed [M:0]     diff;
   logic signed [PW-1:0]  diff_w;
   logic signed [PW-1:0]  frac_w;
   logic signed [PW-1:0]  sum;

   assign ready = (state == S_IDLE);
   assign wr_ok = lut_we && ready && (int'(lut_addr) <= LUTSIZE) && (int'(lut_ch) < NCH);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CAP;
         S_CAP:   state_nxt = S_RD0;
         S_RD0:   state_nxt = S_RD1;
         S_RD1:   state_nxt = S_MUL;
         S_MUL:   state_nxt = S_OUT;
         S_OUT:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Adding 2^(N-1) to a two's-complement value is just an MSB flip.
   always_comb begin
      u      = {~x_q[N-1], x_q[N-2:0]};
      idx0   = {1'b0, idx_q};
      idx1   = {1'b0, idx_q} + (ADDRBITS+1)'(1);
      diff   = {l1_q[M-1], l1_q} - {l0_q[M-1], l0_q};
      diff_w = PW'(diff);
      frac_w = PW'({1'b0, frac_q});
      sum    = PW'(l0_q) + (prod_q >>> FB);
   end

   // Table contents survive reset, so storage sits outside the reset domain.
   always_ff @(posedge clock) begin
      if (wr_ok) tbl[lut_ch][lut_addr] <= lut_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) lut_drop <= 1'b0;
      else        lut_drop <= lut_we && !wr_ok;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x_q    <= '0;
         ch_q   <= '0;
         idx_q  <= '0;
         frac_q <= '0;
         l0_q   <= '0;
         l1_q   <= '0;
         prod_q <= '0;
         Y      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  x_q  <= X;
                  ch_q <= (int'(ch) < NCH) ? ch : '0;
               end
            end
            S_CAP: begin
               idx_q  <= u[N-1:FB];
               frac_q <= u[FB-1:0];
            end
            S_RD0:   l0_q   <= tbl[ch_q][idx0];
            S_RD1:   l1_q   <= tbl[ch_q][idx1];
            S_MUL:   prod_q <= diff_w * frac_w;
            S_OUT:   Y      <= sum[M-1:0];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_interpol_mc.sv
// Directed and randomized checks of interpol_mc against a floor-division reference model.
module tb_interpol_mc;

   localparam int LUTSIZE  = 16;
   localparam int ADDRBITS = 4;
   localparam int N        = 16;
   localparam int M        = 16;
   localparam int NCH      = 2;
   localparam int CHBITS   = 1;
   localparam int FB       = N - ADDRBITS;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [CHBITS-1:0]   ch = '0;
   logic signed [N-1:0] X = '0;
   logic                ready;
   logic signed [M-1:0] Y;
   logic                lut_we = 1'b0;
   logic [CHBITS-1:0]   lut_ch = '0;
   logic [ADDRBITS:0]   lut_addr = '0;
   logic signed [M-1:0] lut_data = '0;
   logic                lut_drop;

   int tbl_m [NCH][LUTSIZE+1];
   int total  = 0;
   int passed = 0;
   int cyc    = 0;

   interpol_mc dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .ch       (ch),
      .X        (X),
      .ready    (ready),
      .Y        (Y),
      .lut_we   (lut_we),
      .lut_ch   (lut_ch),
      .lut_addr (lut_addr),
      .lut_data (lut_data),
      .lut_drop (lut_drop)
   );

   always #5 clock = ~clock;
   always @(negedge clock) cyc++;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int floor_div(int n, int d);
      int q;
      q = n / d;
      if ((n % d) != 0 && n < 0) q = q - 1;
      return q;
   endfunction

   // Breakpoints sit 2^FB apart across the full signed input range.
   function automatic int model(int c, int x);
      int u, i, f, y0, y1;
      u  = x + 2**(N-1);
      i  = u / 2**FB;
      f  = u % 2**FB;
      y0 = tbl_m[c][i];
      y1 = tbl_m[c][i+1];
      return y0 + floor_div((y1 - y0) * f, 2**FB);
   endfunction

   task automatic wr(input int c, input int a, input int d, input bit expect_ok);
      @(negedge clock);
      lut_we = 1'b1; lut_ch = c[CHBITS-1:0]; lut_addr = a[ADDRBITS:0]; lut_data = d[M-1:0];
      @(negedge clock);
      lut_we = 1'b0;
      chk("lut_drop", {31'd0, lut_drop}, expect_ok ? 0 : 1);
      if (expect_ok) tbl_m[c][a] = d;
   endtask

   task automatic wait_ready(output int lat);
      lat = 0;
      while (!ready && lat < 20) begin
         @(negedge clock);
         lat++;
      end
   endtask

   // One transaction from IDLE, optionally with a table write on the start edge.
   task automatic tx(input string tag, input int c, input int x, input bit we, input int wa, input int wd,
                     output logic signed [M-1:0] y);
      int lat;
      @(negedge clock);
      start = 1'b1; ch = c[CHBITS-1:0]; X = x[N-1:0];
      if (we) begin
         lut_we = 1'b1; lut_ch = c[CHBITS-1:0]; lut_addr = wa[ADDRBITS:0]; lut_data = wd[M-1:0];
      end
      @(negedge clock);
      start = 1'b0; lut_we = 1'b0;
      if (we) tbl_m[c][wa] = wd;
      chk({tag, "_busy"}, {31'd0, ready}, 0);
      wait_ready(lat);
      chk({tag, "_lat"}, lat, 5);
      chk({tag, "_y"}, Y, model(c, x));
      y = Y;
   endtask

   initial begin
      logic signed [M-1:0] y;
      int lat, rises, prev, c, x;
      int rise_cyc[$];

      // Asynchronous reset with no clock edge needed.
      #2 reset = 1'b0;
      #1;
      chk("rst_ready", {31'd0, ready}, 1);
      chk("rst_y", Y, 0);
      chk("rst_drop", {31'd0, lut_drop}, 0);
      @(negedge clock);
      reset = 1'b1;

      // Linear ramp on ch0, steep negative first segment on ch1.
      for (int k = 0; k <= LUTSIZE; k++) wr(0, k, k * 256, 1'b1);
      for (int k = 0; k <= LUTSIZE; k++) wr(1, k, (k == 0) ? 1000 : 0, 1'b1);

      tx("lin_min", 0, -32768, 1'b0, 0, 0, y); chk("lin_min_c", y, 0);
      tx("lin_0",   0, 0,      1'b0, 0, 0, y); chk("lin_0_c", y, 2048);
      tx("lin_2k",  0, 2048,   1'b0, 0, 0, y); chk("lin_2k_c", y, 2176);
      tx("lin_max", 0, 32767,  1'b0, 0, 0, y); chk("lin_max_c", y, 4095);
      tx("neg_mid", 1, -30720, 1'b0, 0, 0, y); chk("neg_mid_c", y, 500);
      tx("neg_1",   1, -32767, 1'b0, 0, 0, y); chk("neg_1_c", y, 999);
      tx("iso_0",   0, 2048,   1'b0, 0, 0, y); chk("iso_0_c", y, 2176);

      // start pulsed while busy must not queue a second transaction.
      @(negedge clock);
      start = 1'b1; ch = 1'b0; X = 16'sd0;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      rises = 0; prev = 0;
      for (int k = 0; k < 20; k++) begin
         if (ready && !prev) rises++;
         prev = ready;
         @(negedge clock);
      end
      chk("busy_start_rises", rises, 1);
      chk("busy_start_y", Y, 2048);

      // Table write while busy is dropped and leaves the table untouched.
      @(negedge clock);
      start = 1'b1; ch = 1'b0; X = 16'sd0;
      @(negedge clock);
      start = 1'b0;
      lut_we = 1'b1; lut_ch = 1'b0; lut_addr = 5'd8; lut_data = 16'sd7777;
      @(negedge clock);
      lut_we = 1'b0;
      chk("busy_wr_drop", {31'd0, lut_drop}, 1);
      wait_ready(lat);
      chk("busy_wr_lat", lat, 4);
      tx("busy_wr_rb", 0, 0, 1'b0, 0, 0, y); chk("busy_wr_rb_c", y, 2048);

      wr(0, 17, 1234, 1'b0);
      @(negedge clock);
      chk("drop_pulse_end", {31'd0, lut_drop}, 0);

      tx("simul", 0, 0, 1'b1, 8, 5000, y); chk("simul_c", y, 5000);

      // Reset two cycles into a transaction aborts it.
      @(negedge clock);
      start = 1'b1; ch = 1'b0; X = 16'sd2048;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("abort_ready", {31'd0, ready}, 1);
      chk("abort_y", Y, 0);
      @(negedge clock);
      reset = 1'b1;
      chk("abort_y_hold", Y, 0);
      tx("post_rst", 0, 2048, 1'b0, 0, 0, y); chk("post_rst_c", y, 3652);

      // start held high: one result every 6 cycles.
      @(negedge clock);
      start = 1'b1; ch = 1'b1; X = -16'sd30720;
      prev = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (ready && !prev) begin
            rise_cyc.push_back(cyc);
            chk("b2b_y", Y, 500);
         end
         prev = ready;
      end
      start = 1'b0;
      wait_ready(lat);
      chk("b2b_rises", (rise_cyc.size() >= 3) ? 1 : 0, 1);
      if (rise_cyc.size() >= 3) begin
         chk("b2b_period0", rise_cyc[1] - rise_cyc[0], 6);
         chk("b2b_period1", rise_cyc[2] - rise_cyc[1], 6);
      end

      // Random tables on both channels, then endpoints and random samples.
      for (int cc = 0; cc < NCH; cc++)
         for (int k = 0; k <= LUTSIZE; k++)
            wr(cc, k, int'($urandom_range(0, 65535)) - 32768, 1'b1);
      for (int cc = 0; cc < NCH; cc++) begin
         tx("ep_min", cc, -32768, 1'b0, 0, 0, y); chk("ep_min_t0", y, tbl_m[cc][0]);
         tx("ep_max", cc, 32767,  1'b0, 0, 0, y);
         tx("ep_m1",  cc, -1,     1'b0, 0, 0, y);
         tx("ep_0",   cc, 0,      1'b0, 0, 0, y);
      end
      for (int k = 0; k < 3000; k++) begin
         c = int'($urandom_range(0, NCH - 1));
         x = int'($urandom_range(0, 65535)) - 32768;
         tx("rnd", c, x, 1'b0, 0, 0, y);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
